// File: rtl/strb_divider_pkg.sv
// Shared types for the multi-channel strobe divider.
// Latency: n/a (types only).
// Backpressure: n/a.
package strb_divider_pkg;

  // Channel operating mode, latched when the channel is started.
  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  // Per-channel control state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage : strb_divider_pkg

// File: rtl/strb_divider_ch.sv
// One strobe-divider channel: counts enabled cycles and emits a strobe every D_eff of them.
// Latency: first strobe D_eff enabled cycles after start is sampled; busy_o trails state by one cycle.
// Backpressure: none; en_i low freezes counter and state.
//
// Ports:
//   clk_i, arstn_i : clock, asynchronous active-low reset
//   en_i           : count enable (low pauses the channel)
//   start_i        : start/restart pulse, honoured in any state regardless of en_i
//   mode_i         : 0 periodic, 1 one-shot; sampled on start_i
//   div_i          : divisor D (0 treated as 1)
//   strb_o         : registered single-cycle strobe
//   busy_o         : registered copy of (state == RUN)
module strb_divider_ch
  import strb_divider_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic                 en_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [CNT_WIDTH-1:0] div_i,
  output logic                 strb_o,
  output logic                 busy_o
);

  state_e               r_state;
  state_e               w_state_nxt;
  mode_e                r_mode;
  mode_e                w_mode_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_strb;
  logic                 w_strb_nxt;
  logic                 r_busy;
  logic [CNT_WIDTH-1:0] w_reload;

  // Reload value D_eff-1: a zero divisor behaves like one, so the reload is
  // zero in both cases and the subtraction never wraps.
  assign w_reload = (div_i == '0) ? '0 : (div_i - 1'b1);

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_strb_nxt  = 1'b0;

    if (start_i) begin
      // Restart wins over a coincident terminal count: no strobe this time.
      w_state_nxt = ST_RUN;
      w_mode_nxt  = mode_e'(mode_i);
      w_cnt_nxt   = w_reload;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (en_i) begin
            if (r_cnt != '0) begin
              w_cnt_nxt = r_cnt - 1'b1;
            end else begin
              w_strb_nxt = 1'b1;
              if (r_mode == MODE_PERIODIC) begin
                // Divisor is re-sampled only here, so changes take
                // effect at the period boundary.
                w_cnt_nxt = w_reload;
              end else begin
                w_state_nxt = ST_IDLE;
              end
            end
          end
        end
        default: begin
          // IDLE: counter holds, no strobe.
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_PERIODIC;
      r_cnt   <= '0;
      r_strb  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_cnt   <= w_cnt_nxt;
      r_strb  <= w_strb_nxt;
      // Registered from the current state, so it rises the cycle after RUN
      // is entered and falls the cycle after a one-shot returns to IDLE.
      r_busy  <= (r_state == ST_RUN);
    end
  end

  assign strb_o = r_strb;
  assign busy_o = r_busy;

endmodule : strb_divider_ch

// File: rtl/strb_divider_multi.sv
// NUM_CH independent strobe dividers sharing one clock and reset.
// Latency: per channel, first strobe D_eff enabled cycles after start is sampled.
// Backpressure: none; per-channel en_i pauses that channel only.
//
// Ports (bit/slice i belongs to channel i):
//   clk_i, arstn_i : clock, asynchronous active-low reset
//   en_i           : [NUM_CH-1:0] count enables
//   start_i        : [NUM_CH-1:0] start/restart pulses
//   mode_i         : [NUM_CH-1:0] 0 periodic, 1 one-shot
//   div_i          : [NUM_CH*CNT_WIDTH-1:0] divisors, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   strb_o         : [NUM_CH-1:0] strobes
//   busy_o         : [NUM_CH-1:0] busy flags
module strb_divider_multi
  import strb_divider_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          arstn_i,
  input  logic [NUM_CH-1:0]             en_i,
  input  logic [NUM_CH-1:0]             start_i,
  input  logic [NUM_CH-1:0]             mode_i,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   div_i,
  output logic [NUM_CH-1:0]             strb_o,
  output logic [NUM_CH-1:0]             busy_o
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    strb_divider_ch #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .en_i    (en_i[g]),
      .start_i (start_i[g]),
      .mode_i  (mode_i[g]),
      .div_i   (div_i[g*CNT_WIDTH +: CNT_WIDTH]),
      .strb_o  (strb_o[g]),
      .busy_o  (busy_o[g])
    );
  end

endmodule : strb_divider_multi

// File: tb/tb_strb_divider_multi.sv
// Testbench for strb_divider_multi (NUM_CH=4, CNT_WIDTH=16).
// Cycle k means the state just after rising edge k; inputs for cycle k are
// driven on the preceding falling edge and sampled at edge k.
module tb_strb_divider_multi;

  localparam int NCH = 4;
  localparam int CW  = 16;

  logic                clk_i;
  logic                arstn_i;
  logic [NCH-1:0]      en_i;
  logic [NCH-1:0]      start_i;
  logic [NCH-1:0]      mode_i;
  logic [NCH*CW-1:0]   div_i;
  logic [NCH-1:0]      strb_o;
  logic [NCH-1:0]      busy_o;

  typedef struct packed {
    logic [NCH-1:0] strb;
    logic [NCH-1:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  strb_divider_multi #(
    .NUM_CH    (NCH),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .en_i    (en_i),
    .start_i (start_i),
    .mode_i  (mode_i),
    .div_i   (div_i),
    .strb_o  (strb_o),
    .busy_o  (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic set_div(input int ch, input int d);
    div_i[ch*CW +: CW] = d[CW-1:0];
  endtask

  task automatic do_reset();
    arstn_i = 1'b0;
    en_i    = '0;
    start_i = '0;
    mode_i  = '0;
    div_i   = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    arstn_i = 1'b1;
  endtask

  // Pop the oldest expectation and compare both outputs for cycle k.
  task automatic check_cycle(input string name, input int k);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty at cyc=%0d got=empty exp=entry", name, k);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (strb_o !== e.strb) begin
        bad++;
        $display("FAIL %s strb cyc=%0d got=%b exp=%b", name, k, strb_o, e.strb);
      end
      total++;
      if (busy_o !== e.busy) begin
        bad++;
        $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, k, busy_o, e.busy);
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    arstn_i = 1'b0;
    en_i    = '1;
    start_i = '0;
    mode_i  = '0;
    div_i   = '0;
    repeat (3) @(posedge clk_i);
    #1;
    total++;
    if (strb_o !== '0 || busy_o !== '0) begin
      bad++;
      $display("FAIL reset_hold got strb=%b busy=%b exp strb=0000 busy=0000", strb_o, busy_o);
    end
    @(negedge clk_i);
    arstn_i = 1'b1;
    // With no start the channels must stay idle even though enabled.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      for (int c = 0; c < NCH; c++) set_div(c, 3);
      e.strb = '0;
      e.busy = '0;
      exp_q.push_back(e);
      @(posedge clk_i);
      #1;
      check_cycle("reset_idle", k);
    end
  endtask

  task automatic test_periodic();
    exp_t e;
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk_i);
      en_i    = 4'b0001;
      start_i = (k == 0) ? 4'b0001 : 4'b0000;
      mode_i  = 4'b0000;
      set_div(0, 5);
      e.strb = (k == 5 || k == 10 || k == 15) ? 4'b0001 : 4'b0000;
      e.busy = (k >= 1) ? 4'b0001 : 4'b0000;
      exp_q.push_back(e);
      @(posedge clk_i);
      #1;
      check_cycle("periodic_d5", k);
    end
  endtask

  task automatic test_oneshot();
    exp_t e;
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk_i);
      en_i    = 4'b0010;
      start_i = (k == 0) ? 4'b0010 : 4'b0000;
      mode_i  = 4'b0010;
      set_div(1, 3);
      e.strb = (k == 3) ? 4'b0010 : 4'b0000;
      e.busy = (k >= 1 && k <= 3) ? 4'b0010 : 4'b0000;
      exp_q.push_back(e);
      @(posedge clk_i);
      #1;
      check_cycle("oneshot_d3", k);
    end
  endtask

  task automatic test_div_small();
    exp_t e;
    do_reset();
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk_i);
      en_i    = 4'b1100;
      start_i = (k == 0) ? 4'b1100 : 4'b0000;
      mode_i  = 4'b0000;
      set_div(2, 0);
      set_div(3, 1);
      e.strb = (k >= 1) ? 4'b1100 : 4'b0000;
      e.busy = (k >= 1) ? 4'b1100 : 4'b0000;
      exp_q.push_back(e);
      @(posedge clk_i);
      #1;
      check_cycle("div_0_1", k);
    end
  endtask

  task automatic test_pause();
    exp_t e;
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk_i);
      en_i    = (k >= 2 && k <= 4) ? 4'b0000 : 4'b0001;
      start_i = (k == 0) ? 4'b0001 : 4'b0000;
      mode_i  = 4'b0000;
      set_div(0, 4);
      e.strb = (k == 7 || k == 11) ? 4'b0001 : 4'b0000;
      e.busy = (k >= 1) ? 4'b0001 : 4'b0000;
      exp_q.push_back(e);
      @(posedge clk_i);
      #1;
      check_cycle("pause", k);
    end
  endtask

  // Divisor drops to 2 mid-period (applies at the next boundary); a restart
  // coinciding with the terminal count at edge 8 suppresses that strobe and
  // reloads with D=4.
  task automatic test_div_change();
    exp_t e;
    do_reset();
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk_i);
      en_i    = 4'b0001;
      start_i = (k == 0 || k == 8) ? 4'b0001 : 4'b0000;
      mode_i  = 4'b0000;
      set_div(0, (k >= 2 && k < 8) ? 2 : 4);
      e.strb = (k == 4 || k == 6 || k == 12 || k == 16) ? 4'b0001 : 4'b0000;
      e.busy = (k >= 1) ? 4'b0001 : 4'b0000;
      exp_q.push_back(e);
      @(posedge clk_i);
      #1;
      check_cycle("div_change", k);
    end
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    do_reset();
    // ch0 periodic D=3, ch1 one-shot D=2, ch2 periodic D=5, ch3 one-shot D=4
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk_i);
      en_i    = 4'b1111;
      start_i = (k == 0) ? 4'b1111 : 4'b0000;
      mode_i  = 4'b1010;
      set_div(0, 3);
      set_div(1, 2);
      set_div(2, 5);
      set_div(3, 4);
      e.strb[0] = (k == 3 || k == 6);
      e.strb[1] = (k == 2);
      e.strb[2] = (k == 5);
      e.strb[3] = (k == 4);
      e.busy[0] = (k >= 1);
      e.busy[1] = (k >= 1 && k <= 2);
      e.busy[2] = (k >= 1);
      e.busy[3] = (k >= 1 && k <= 4);
      exp_q.push_back(e);
      @(posedge clk_i);
      #1;
      check_cycle("mixed_pre_reset", k);
    end
    // Asynchronous assertion between edges must clear outputs immediately.
    #2;
    arstn_i = 1'b0;
    #1;
    total++;
    if (strb_o !== '0 || busy_o !== '0) begin
      bad++;
      $display("FAIL async_reset got strb=%b busy=%b exp strb=0000 busy=0000", strb_o, busy_o);
    end
    @(negedge clk_i);
    arstn_i = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk_i);
      en_i    = 4'b1111;
      start_i = 4'b0000;
      e.strb  = '0;
      e.busy  = '0;
      exp_q.push_back(e);
      @(posedge clk_i);
      #1;
      check_cycle("post_reset_idle", k);
    end
    // Only ch2 restarted; the others stay quiet.
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk_i);
      start_i = (k == 0) ? 4'b0100 : 4'b0000;
      e.strb  = (k == 5) ? 4'b0100 : 4'b0000;
      e.busy  = (k >= 1) ? 4'b0100 : 4'b0000;
      exp_q.push_back(e);
      @(posedge clk_i);
      #1;
      check_cycle("post_reset_start", k);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    arstn_i = 1'b0;
    en_i    = '0;
    start_i = '0;
    mode_i  = '0;
    div_i   = '0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_div_small();
    test_pause();
    test_div_change();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_strb_divider_multi
